// File: rtl/demux_pkg.sv
// Shared definitions for the demux stream router.
// Provides the default data width and channel count, the drop counter width,
// and a helper that turns a channel index into a one-hot channel mask.
package demux_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned NCH_DEF    = 4;
  localparam int unsigned DROP_CNT_W = 8;

  // Widest channel mask onehot() can build; callers slice it down to NCH bits.
  localparam int unsigned MAX_NCH    = 64;

  // Channel index -> one-hot mask. An index beyond MAX_NCH yields an all-zero mask.
  function automatic logic [MAX_NCH-1:0] onehot(input int unsigned idx);
    return MAX_NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_stream_router_sat_counter.sv
// Saturating up-counter with an increment enable.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset; clears count
//   inc   - add one at the next edge unless already at the maximum value
//   count - current value; it holds at all-ones once saturated
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // The increment is suppressed at all-ones so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-NCH stream demultiplexer with broadcast support.
// One beat is held at a time. Each of its destination channels is tracked in a
// pending mask, and the beat retires when the last of those channels accepts it.
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   in_valid   - producer has a beat
//   in_ready   - a beat can be accepted this cycle (combinational on out_ready)
//   in_data    - beat payload
//   in_sel     - destination channel index
//   in_bcast   - deliver the beat to every channel; in_sel is ignored
//   out_valid  - per-channel valid (the pending mask)
//   out_ready  - per-channel ready
//   out_data   - held payload, shared by all channels
//   err_sel    - one-cycle pulse after a beat with an out-of-range select is dropped
//   drop_cnt   - saturating count of dropped beats
module demux_stream_router
  import demux_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NCH   = NCH_DEF,
  localparam int unsigned SELW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_bcast,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  err_sel,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   pending_nxt_c;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt_c;
  logic             err_q;
  logic             accept_c;
  logic             sel_ok_c;
  logic             drop_c;

  // Ready when every channel still owed the held beat completes this cycle.
  // This is also true when nothing is held, so a new beat enters with no bubble.
  assign in_ready = ((pending & ~out_ready) == '0);
  assign accept_c = in_valid & in_ready;

  // A select value is out of range only when NCH is not a power of two.
  assign sel_ok_c = in_bcast | (32'(in_sel) < NCH);
  assign drop_c   = accept_c & ~sel_ok_c;

  // Next mask and payload. When a beat is accepted, every old pending bit has
  // completed, so the new mask simply replaces the old one.
  always_comb begin
    pending_nxt_c = pending & ~out_ready;
    data_nxt_c    = data_q;
    if (accept_c) begin
      if (in_bcast) begin
        pending_nxt_c = '1;
        data_nxt_c    = in_data;
      end else if (sel_ok_c) begin
        pending_nxt_c = NCH'(onehot(32'(in_sel)));
        data_nxt_c    = in_data;
      end else begin
        pending_nxt_c = '0;
      end
    end
  end

  // Holding register and error pulse. Reset discards a held beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      pending <= pending_nxt_c;
      data_q  <= data_nxt_c;
      err_q   <= drop_c;
    end
  end

  sat_counter #(
    .W (DROP_CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_c),
    .count (drop_cnt)
  );

  assign out_valid = pending;
  assign out_data  = data_q;
  assign err_sel   = err_q;

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router. Two instances share one stimulus stream:
// u4 has NCH=4 and u3 has NCH=3, so on u3 an in_sel of 3 is an illegal select.
// Each instance is checked against a model that records which channels are
// still owed the current beat, plus the payload and the drop statistics.
module tb_demux_stream_router;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_sel = 2'd0;
  logic       in_bcast = 1'b0;
  logic [3:0] out_ready = 4'h0;

  logic [3:0] o4_valid;
  logic [7:0] o4_data;
  logic       o4_ready;
  logic       o4_err;
  logic [7:0] o4_drop;
  logic [2:0] o3_valid;
  logic [7:0] o3_data;
  logic       o3_ready;
  logic       o3_err;
  logic [7:0] o3_drop;

  int vectors = 0;
  int miscompares = 0;

  demux_stream_router #(.WIDTH(8), .NCH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o4_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(o4_valid), .out_ready(out_ready), .out_data(o4_data),
    .err_sel(o4_err), .drop_cnt(o4_drop)
  );

  demux_stream_router #(.WIDTH(8), .NCH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o3_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(o3_valid), .out_ready(out_ready[2:0]), .out_data(o3_data),
    .err_sel(o3_err), .drop_cnt(o3_drop)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 is the NCH=4 instance, index 1 the NCH=3 instance.
  bit   [3:0] owed   [2];
  logic [7:0] m_data [2];
  int         m_drop [2];
  bit         m_err  [2];

  function automatic int nch_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      owed[d]   = 4'h0;
      m_data[d] = 8'h00;
      m_drop[d] = 0;
      m_err[d]  = 1'b0;
    end
  endfunction

  // The producer may hand over a beat once no owed channel is left waiting.
  function automatic bit model_ready(input int d);
    for (int k = 0; k < nch_of(d); k++)
      if (owed[d][k] && !out_ready[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clock();
    for (int d = 0; d < 2; d++) begin
      bit take;
      take = in_valid && model_ready(d);
      for (int k = 0; k < nch_of(d); k++)
        if (out_ready[k]) owed[d][k] = 1'b0;
      m_err[d] = 1'b0;
      if (take) begin
        if (in_bcast) begin
          owed[d] = 4'h0;
          for (int k = 0; k < nch_of(d); k++) owed[d][k] = 1'b1;
          m_data[d] = in_data;
        end else if (int'(in_sel) < nch_of(d)) begin
          owed[d] = 4'h0;
          owed[d][in_sel] = 1'b1;
          m_data[d] = in_data;
        end else begin
          m_err[d]  = 1'b1;
          m_drop[d] = (m_drop[d] >= 255) ? 255 : m_drop[d] + 1;
        end
      end
    end
  endfunction

  function automatic logic [42:0] expected();
    return {owed[0], m_data[0], model_ready(0), m_err[0], 8'(m_drop[0]),
            owed[1][2:0], m_data[1], model_ready(1), m_err[1], 8'(m_drop[1])};
  endfunction

  function automatic logic [42:0] observed();
    return {o4_valid, o4_data, o4_ready, o4_err, o4_drop,
            o3_valid, o3_data, o3_ready, o3_err, o3_drop};
  endfunction

  // Lets the model and the DUTs take one edge; inputs may be changed afterwards.
  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit b, input logic [1:0] s,
                       input logic [7:0] dat, input logic [3:0] rdy);
    in_valid = v; in_bcast = b; in_sel = s; in_data = dat; out_ready = rdy;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b1, 1'b1, 2'd1, 8'hFF, 4'hF);
    @(negedge clk);
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", observed(), expected());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
    @(negedge clk);
    vectors++;
    if (o4_valid !== 4'h0 || o4_data !== 8'h00 || o4_drop !== 8'h00 || o4_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", observed(), expected());
    end
    advance();
  endtask

  task automatic test_unicast_sweep();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 2'(i), 8'(8'hA0 + i), 4'hF);
      else       drive(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
      @(negedge clk);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL unicast_sweep[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'hF};
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(1'b1, 1'b0, 2'd2, 8'h5C, rdy[i]);
      else if (i < 5)  drive(1'b1, 1'b0, 2'd1, 8'h77, rdy[i]);
      else             drive(1'b0, 1'b0, 2'd0, 8'h00, rdy[i]);
      @(negedge clk);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL backpressure[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
  endtask

  task automatic test_bcast_staggered();
    logic [3:0] rdy [5] = '{4'h0, 4'h1, 4'h8, 4'h6, 4'hF};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 2'd0, 8'h3E, rdy[i]);
      else        drive(1'b1, 1'b0, 2'd0, 8'h11, rdy[i]);
      @(negedge clk);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL bcast_staggered[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
  endtask

  task automatic test_illegal_select();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 2'd3, 8'($urandom), 4'hF);
      @(negedge clk);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL illegal_select[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    @(negedge clk);
    vectors++;
    if (o3_drop !== 8'd255 || o3_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL drop_saturate got=%0d/%b want=255/000", o3_drop, o3_valid);
    end
    advance();
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 1'b1, 2'd0, 8'hC4, 4'h0);
    advance();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h5);
    advance();
    vectors++;
    if (o4_valid !== 4'b1010) begin
      miscompares++;
      $display("FAIL hold_before_reset got=%b want=1010", o4_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (o4_valid !== 4'h0 || o4_drop !== 8'h00 || o3_valid !== 3'h0 || o3_drop !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset got=%b/%0d/%b/%0d want=0000/0/000/0",
               o4_valid, o4_drop, o3_valid, o3_drop);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b1, 1'b0, 2'd1, 8'h9A, 4'hF);
      else        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
      @(negedge clk);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL after_reset[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
      @(negedge clk);
      vectors++;
      if (observed() !== expected() || o4_valid !== 4'h0) begin
        miscompares++;
        $display("FAIL idle[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            2'($urandom), 8'($urandom), 4'($urandom));
      @(negedge clk);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL random[%0d] got=%h want=%h", i, observed(), expected());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_unicast_sweep();
    test_backpressure();
    test_bcast_staggered();
    test_illegal_select();
    test_reset_mid_hold();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
